// File: rtl/pwm_key_ctrl.sv
// pwm_key_ctrl: two push keys (up/down) step a duty register that drives a
// registered, glitch-free PWM output.
// Each raw key is synchronised by two flops and then debounced. A four-state
// FSM (IDLE/UP/DOWN/LOCK) turns clean key presses into single duty steps.
// The duty steps saturate at 0 and at 2^WIDTH-1.
// Optional build macro PWM_KEY_AUTOREPEAT_EN: while a key stays held in UP or
// DOWN, a further step is applied every REPEAT_CYCLES cycles.
module pwm_key_ctrl #(
  parameter int WIDTH           = 8,
  parameter int STEP            = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_up,
  input  logic             key_down,
  output logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             step_strobe,
  output logic             sat
);

  localparam logic [WIDTH-1:0] DUTY_MAX = '1;
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [7:0]       DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("pwm_key_ctrl: DEBOUNCE_CYCLES must be 1..255 and REPEAT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, UP, DOWN, LOCK} state_t;

  // Saturating increment by STEP; the extra MSB catches the overflow.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] s;
    s = {1'b0, d} + STEP_X;
    return s[WIDTH] ? DUTY_MAX : s[WIDTH-1:0];
  endfunction

  // Saturating decrement by STEP; clamps at zero.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] d);
    if ({1'b0, d} < STEP_X) return '0;
    return d - STEP_X[WIDTH-1:0];
  endfunction

  // Bit 0 is the up key and bit 1 is the down key throughout.
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [7:0]       r_dcnt [2];
  logic             w_up;
  logic             w_dn;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_inc;
  logic             w_dec;
  logic [WIDTH-1:0] w_duty_nxt;

  logic [WIDTH-1:0] r_duty;
  logic             r_strobe;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_active;
  logic             r_pwm;

  assign w_raw = {key_down, key_up};
  assign w_up  = r_deb[0];
  assign w_dn  = r_deb[1];

  // Two-flop synchroniser for both raw keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce each key: flip after DEBOUNCE_CYCLES differing samples; a matching sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= '0;
      for (int k = 0; k < 2; k++) r_dcnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_dcnt[k] <= '0;
        end else if (r_dcnt[k] == DB_LAST) begin
          r_deb[k]  <= ~r_deb[k];
          r_dcnt[k] <= '0;
        end else begin
          r_dcnt[k] <= r_dcnt[k] + 8'd1;
        end
      end
    end
  end

`ifdef PWM_KEY_AUTOREPEAT_EN
  localparam int             REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep;

  // Repeat interval counter; restarts on every state change and outside UP/DOWN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep <= '0;
    end else if (w_state_nxt != r_state || (r_state != UP && r_state != DOWN) ||
                 r_rep == REP_LAST) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end
`endif

  // Next state, step requests and next duty value.
  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_up && w_dn) begin
          w_state_nxt = LOCK;
        end else if (w_up) begin
          w_state_nxt = UP;
          w_inc       = 1'b1;
        end else if (w_dn) begin
          w_state_nxt = DOWN;
          w_dec       = 1'b1;
        end
      end
      UP: begin
        if (w_dn)       w_state_nxt = LOCK;
        else if (!w_up) w_state_nxt = IDLE;
      end
      DOWN: begin
        if (w_up)       w_state_nxt = LOCK;
        else if (!w_dn) w_state_nxt = IDLE;
      end
      LOCK: begin
        if (!w_up && !w_dn) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef PWM_KEY_AUTOREPEAT_EN
    if (r_rep == REP_LAST) begin
      if (r_state == UP && w_state_nxt == UP)     w_inc = 1'b1;
      if (r_state == DOWN && w_state_nxt == DOWN) w_dec = 1'b1;
    end
`endif
    w_duty_nxt = r_duty;
    if (w_inc)      w_duty_nxt = sat_inc(r_duty);
    else if (w_dec) w_duty_nxt = sat_dec(r_duty);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Duty register; the strobe marks only real changes, so saturated presses stay silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_duty   <= w_duty_nxt;
      r_strobe <= (w_duty_nxt != r_duty);
    end
  end

  // Free-running PWM counter; the active duty is reloaded only on wrap, so a period never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == DUTY_MAX) r_active <= r_duty;
      r_pwm <= (r_cnt < r_active);
    end
  end

  assign duty        = r_duty;
  assign pwm_out     = r_pwm;
  assign step_strobe = r_strobe;
  assign sat         = (r_duty == '0) || (r_duty == DUTY_MAX);

endmodule

// File: tb/tb_pwm_key_ctrl.sv
// Testbench for pwm_key_ctrl (WIDTH=8, STEP=32, DEBOUNCE_CYCLES=4, default build).
// Expected duty values are queued whenever a press is driven and are popped
// and compared whenever step_strobe is seen.
module tb_pwm_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic [7:0] duty;
  logic       pwm_out;
  logic       step_strobe;
  logic       sat;

  pwm_key_ctrl #(
    .WIDTH(8), .STEP(32), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_up(key_up), .key_down(key_down),
    .duty(duty), .pwm_out(pwm_out), .step_strobe(step_strobe), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         up;
    bit         dn;
    int         hold;
    logic [7:0] exp_duty;
    int         exp_strobes;
    bit         exp_sat;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge. Every strobe pops the scoreboard.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (step_strobe === 1'b1) begin
      strobes++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: duty now %0d, no change expected", duty);
      end else begin
        check("sb_duty", {24'd0, duty}, {24'd0, sb.pop_front()});
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit u, input bit d, input int hold);
    key_up   = u;
    key_down = d;
    ticks(hold);
    key_up   = 1'b0;
    key_down = 1'b0;
    ticks(12);
  endtask

  // Advance until the next PWM period starts, then count high cycles over one period.
  task automatic pwm_period(output int hi);
    while (cyc % 256 != 0) tick();
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      tick();
      hi += int'(pwm_out);
    end
  endtask

  function automatic void add(input bit u, input bit d, input int hold,
                              input logic [7:0] ed, input int es, input bit esat);
    vec_t v;
    v.up = u; v.dn = d; v.hold = hold;
    v.exp_duty = ed; v.exp_strobes = es; v.exp_sat = esat;
    tbl.push_back(v);
  endfunction

  initial begin
    int         hi;
    int         first;
    int         chg;
    logic [7:0] d;

    // Table: first press, glitch, climb to saturation, minimum-length press, descend to 0.
    add(1, 0, 20, 8'd32, 1, 0);
    add(0, 1, 3,  8'd32, 0, 0);
    for (int k = 2; k <= 7; k++) add(1, 0, 8, 8'(k * 32), 1, 0);
    add(1, 0, 8, 8'd255, 1, 1);
    add(1, 0, 8, 8'd255, 0, 1);
    add(1, 0, 8, 8'd255, 0, 1);
    add(0, 1, 4, 8'd223, 1, 0);
    add(0, 1, 3, 8'd223, 0, 0);
    for (int k = 1; k <= 6; k++) add(0, 1, 8, 8'(223 - 32 * k), 1, 0);
    add(0, 1, 8, 8'd0, 1, 1);
    add(0, 1, 8, 8'd0, 0, 1);

    // Reset state
    rst_n = 1'b0;
    ticks(3);
    check("rst_duty",   {24'd0, duty}, 32'd0);
    check("rst_pwm",    {31'd0, pwm_out}, 32'd0);
    check("rst_strobe", {31'd0, step_strobe}, 32'd0);
    check("rst_sat",    {31'd0, sat}, 32'd1);
    rst_n = 1'b1;
    cyc = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      strobes = 0;
      if (tbl[i].exp_strobes == 1) sb.push_back(tbl[i].exp_duty);
      press(tbl[i].up, tbl[i].dn, tbl[i].hold);
      check($sformatf("vec%0d_duty", i), {24'd0, duty}, {24'd0, tbl[i].exp_duty});
      check($sformatf("vec%0d_strobes", i), strobes, tbl[i].exp_strobes);
      check($sformatf("vec%0d_sat", i), {31'd0, sat}, {31'd0, tbl[i].exp_sat});
    end

    // Duty 0 gives a constant-low waveform
    pwm_period(hi);
    check("pwm_high_duty0", hi, 0);

    // Press latency: duty changes on the 7th edge that samples the key high
    strobes = 0;
    sb.push_back(8'd32);
    key_up = 1'b1;
    first = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (first == 0 && duty != 8'd0) first = e;
    end
    key_up = 1'b0;
    ticks(12);
    check("latency_edge", first, 7);
    check("latency_strobes", strobes, 1);
    check("latency_sat", {31'd0, sat}, 32'd0);

    // Both keys together lock; releasing only one keeps the lock
    strobes = 0;
    key_up = 1'b1;
    key_down = 1'b1;
    ticks(10);
    key_up = 1'b0;
    ticks(12);
    check("lock_one_released", {24'd0, duty}, 32'd32);
    key_down = 1'b0;
    ticks(12);
    check("lock_both_released", {24'd0, duty}, 32'd32);
    check("lock_strobes", strobes, 0);
    strobes = 0;
    sb.push_back(8'd64);
    press(1, 0, 8);
    check("after_lock_duty", {24'd0, duty}, 32'd64);
    check("after_lock_strobes", strobes, 1);

    // Duty 64->96 mid-period: current period keeps 64, next period shows 96
    while (cyc % 256 != 0) tick();
    hi = 0;
    chg = -1;
    for (int j = 0; j < 256; j++) begin
      tick();
      hi += int'(pwm_out);
      if (chg < 0 && duty == 8'd96) chg = cyc % 256;
      if (cyc % 256 == 94) begin
        sb.push_back(8'd96);
        key_up = 1'b1;
      end
      if (cyc % 256 == 104) key_up = 1'b0;
    end
    check("duty_change_edge", chg, 101);
    check("pwm_high_cur_period", hi, 64);
    hi = 0;
    for (int j = 0; j < 256; j++) begin
      tick();
      hi += int'(pwm_out);
    end
    check("pwm_high_next_period", hi, 96);

    // Drive to full scale: 255 high cycles out of every 256
    d = 8'd96;
    for (int p = 0; p < 5; p++) begin
      d = (int'(d) + 32 > 255) ? 8'd255 : d + 8'd32;
      sb.push_back(d);
      press(1, 0, 8);
    end
    check("full_duty", {24'd0, duty}, 32'd255);
    pwm_period(hi);
    check("pwm_high_duty255", hi, 255);

    // Reset mid-press discards it; a key still held re-debounces as one new press
    key_up = 1'b1;
    ticks(4);
    rst_n = 1'b0;
    ticks(2);
    check("midrst_duty",   {24'd0, duty}, 32'd0);
    check("midrst_strobe", {31'd0, step_strobe}, 32'd0);
    check("midrst_pwm",    {31'd0, pwm_out}, 32'd0);
    check("midrst_sat",    {31'd0, sat}, 32'd1);
    rst_n = 1'b1;
    cyc = 0;
    strobes = 0;
    sb.push_back(8'd32);
    ticks(12);
    key_up = 1'b0;
    ticks(12);
    check("postrst_duty", {24'd0, duty}, 32'd32);
    check("postrst_strobes", strobes, 1);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
